// File: rtl/dual_chan_arb_pkg.sv
// Shared types for the dual-channel arbiter: channel identifier and the
// per-stage tag carried alongside each operand through the shared datapath.
package dual_chan_arb_pkg;

    typedef enum logic {
        CH_A = 1'b0,
        CH_B = 1'b1
    } chan_e;

    // One entry of the issue-tracking pipeline.
    typedef struct packed {
        logic  valid;
        chan_e chan;
    } tag_t;

    localparam tag_t TAG_IDLE = '{valid: 1'b0, chan: CH_A};

    // The round-robin pointer always moves to the channel that did not win.
    function automatic chan_e other_chan(input chan_e c);
        return (c == CH_A) ? CH_B : CH_A;
    endfunction

endpackage

// File: rtl/resp_fifo.sv
// Synchronous response FIFO, one instance per channel. The head is presented
// combinationally (zero when empty); push and pop in the same cycle both land.
module resp_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic          valid,
    output logic [DW-1:0] head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          do_pop;

    assign empty  = (count == '0);
    assign full   = (count == CW'(DEPTH));
    assign do_pop = pop && !empty;
    assign valid  = !empty;
    assign head   = empty ? '0 : mem[rd_ptr];

    // Pointer advance with wrap at DEPTH (DEPTH need not be a power of two).
    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Pointer and occupancy bookkeeping.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= bump(wr_ptr);
            if (do_pop) rd_ptr <= bump(rd_ptr);
            count <= count + CW'(push) - CW'(do_pop);
        end
    end

    // Storage write port.
    // NOTE: the array has no reset; stale entries are never visible because
    // the head is masked by the occupancy count, so clearing it buys nothing.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    // Credit gating upstream must make a push into a full FIFO impossible.
    no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/dual_chan_arb.sv
// Two-channel round-robin arbiter in front of a shared fixed-latency datapath.
// Each issued operand is tracked by a LAT-deep tag pipeline so the result can
// be steered into the owning channel's response FIFO. Per-channel credits
// (in-flight plus queued results) stop a channel from issuing when its FIFO
// could not absorb another result.
module dual_chan_arb
    import dual_chan_arb_pkg::*;
#(
    parameter int DW    = 8,
    parameter int LAT   = 2,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          sig_a_req_valid,
    output logic          sig_a_req_ready,
    input  logic [DW-1:0] sig_a_req_data,
    output logic          sig_a_rsp_valid,
    input  logic          sig_a_rsp_ready,
    output logic [DW-1:0] sig_a_rsp_data,

    input  logic          sig_b_req_valid,
    output logic          sig_b_req_ready,
    input  logic [DW-1:0] sig_b_req_data,
    output logic          sig_b_rsp_valid,
    input  logic          sig_b_rsp_ready,
    output logic [DW-1:0] sig_b_rsp_data,

    output logic          dp_valid,
    output logic [DW-1:0] dp_data_in,
    input  logic [DW-1:0] dp_data_out
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0] credit_a;
    logic [CW-1:0] credit_b;
    logic          elig_a;
    logic          elig_b;
    chan_e         rr;
    chan_e         grant_chan;
    logic          grant_valid;
    logic          grant_a;
    logic          grant_b;
    logic          pop_a;
    logic          pop_b;
    logic          push_a;
    logic          push_b;
    tag_t          tag_q [LAT];
    tag_t          tag_out;

    // Eligibility: requesting and room for one more result. Forced low while
    // reset is asserted so no handshake can complete during reset.
    assign elig_a = rst_n && sig_a_req_valid && (credit_a < CW'(DEPTH));
    assign elig_b = rst_n && sig_b_req_valid && (credit_b < CW'(DEPTH));

    // Round-robin grant: rr wins a tie, a lone eligible channel always wins.
    // NOTE: both outputs get a default before the if-chain so every path
    // assigns them and no latch is inferred.
    always_comb begin
        grant_valid = 1'b0;
        grant_chan  = rr;
        if (elig_a && elig_b) begin
            grant_valid = 1'b1;
            grant_chan  = rr;
        end else if (elig_a) begin
            grant_valid = 1'b1;
            grant_chan  = CH_A;
        end else if (elig_b) begin
            grant_valid = 1'b1;
            grant_chan  = CH_B;
        end
    end

    assign grant_a = grant_valid && (grant_chan == CH_A);
    assign grant_b = grant_valid && (grant_chan == CH_B);

    assign sig_a_req_ready = grant_a;
    assign sig_b_req_ready = grant_b;

    // The winning operand goes straight to the datapath in the grant cycle.
    assign dp_valid   = grant_valid;
    assign dp_data_in = grant_a ? sig_a_req_data :
                        grant_b ? sig_b_req_data : '0;

    // Tag pipeline: stage 0 holds the issue from the previous cycle, so the
    // last stage lines up with dp_data_out exactly LAT cycles after issue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) tag_q[i] <= TAG_IDLE;
        end else begin
            tag_q[0] <= '{valid: grant_valid, chan: grant_chan};
            for (int i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    assign tag_out = tag_q[LAT-1];

    // Results without a valid tag at the last stage are dropped.
    assign push_a = tag_out.valid && (tag_out.chan == CH_A);
    assign push_b = tag_out.valid && (tag_out.chan == CH_B);

    assign pop_a = sig_a_rsp_valid && sig_a_rsp_ready;
    assign pop_b = sig_b_rsp_valid && sig_b_rsp_ready;

    // Credits and the round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            credit_a <= '0;
            credit_b <= '0;
            rr       <= CH_A;
        end else begin
            credit_a <= credit_a + CW'(grant_a) - CW'(pop_a);
            credit_b <= credit_b + CW'(grant_b) - CW'(pop_b);
            if (grant_valid) rr <= other_chan(grant_chan);
        end
    end

    resp_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_a),
        .push_data (dp_data_out),
        .pop       (pop_a),
        .valid     (sig_a_rsp_valid),
        .head      (sig_a_rsp_data)
    );

    resp_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_b),
        .push_data (dp_data_out),
        .pop       (pop_b),
        .valid     (sig_b_rsp_valid),
        .head      (sig_b_rsp_data)
    );

endmodule

// File: tb/tb_dual_chan_arb.sv
// Bench for dual_chan_arb. A transaction-level model (credits as integers,
// in-flight results as a timed queue, FIFOs as queues) predicts every output
// each cycle; directed scenarios add literal expectations on top.
module tb_dual_chan_arb;

    localparam int DW    = 8;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rst_n;
    logic          sig_a_req_valid, sig_a_req_ready, sig_a_rsp_valid, sig_a_rsp_ready;
    logic          sig_b_req_valid, sig_b_req_ready, sig_b_rsp_valid, sig_b_rsp_ready;
    logic [DW-1:0] sig_a_req_data, sig_a_rsp_data, sig_b_req_data, sig_b_rsp_data;
    logic          dp_valid;
    logic [DW-1:0] dp_data_in, dp_data_out;

    dual_chan_arb #(.DW(DW), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sig_a_req_valid (sig_a_req_valid),
        .sig_a_req_ready (sig_a_req_ready),
        .sig_a_req_data  (sig_a_req_data),
        .sig_a_rsp_valid (sig_a_rsp_valid),
        .sig_a_rsp_ready (sig_a_rsp_ready),
        .sig_a_rsp_data  (sig_a_rsp_data),
        .sig_b_req_valid (sig_b_req_valid),
        .sig_b_req_ready (sig_b_req_ready),
        .sig_b_req_data  (sig_b_req_data),
        .sig_b_rsp_valid (sig_b_rsp_valid),
        .sig_b_rsp_ready (sig_b_rsp_ready),
        .sig_b_rsp_data  (sig_b_rsp_data),
        .dp_valid        (dp_valid),
        .dp_data_in      (dp_data_in),
        .dp_data_out     (dp_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Datapath model: result = operand + 1, LAT cycles later.
    logic [DW-1:0] dp_pipe [LAT];
    logic [DW-1:0] dp_cap;
    logic          acc_a, acc_b;
    assign dp_data_out = dp_pipe[LAT-1] + DW'(1);

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = LAT - 1; i > 0; i--) dp_pipe[i] = dp_pipe[i-1];
        dp_pipe[0] = dp_cap;
        if (acc_a) sig_a_req_data = sig_a_req_data + DW'(1);
        if (acc_b) sig_b_req_data = sig_b_req_data + DW'(1);
    endtask

    // ---------------- transaction-level model ----------------
    typedef struct {
        int            chan;
        logic [DW-1:0] data;
        int            due;
    } flight_t;

    bit            model_on = 1'b0;
    int            m_credit [2];
    int            m_rr;
    int            m_cyc = 0;
    logic [DW-1:0] m_fifo_a [$];
    logic [DW-1:0] m_fifo_b [$];
    flight_t       m_flight [$];
    bit            m_ea, m_eb;
    int            m_g;
    logic [DW-1:0] m_exp;
    flight_t       m_f;

    initial begin
        m_credit[0] = 0;
        m_credit[1] = 0;
        m_rr        = 0;
        acc_a       = 1'b0;
        acc_b       = 1'b0;
        dp_cap      = '0;
        forever begin
            @(negedge clk);
            if (model_on) begin
                m_ea = rst_n && sig_a_req_valid && (m_credit[0] < DEPTH);
                m_eb = rst_n && sig_b_req_valid && (m_credit[1] < DEPTH);
                if (m_ea && m_eb) m_g = m_rr;
                else if (m_ea)    m_g = 0;
                else if (m_eb)    m_g = 1;
                else              m_g = -1;
                m_exp = (m_g == 0) ? sig_a_req_data : (m_g == 1) ? sig_b_req_data : '0;

                check("a_req_ready", 32'(sig_a_req_ready), 32'(m_g == 0));
                check("b_req_ready", 32'(sig_b_req_ready), 32'(m_g == 1));
                check("dp_valid",    32'(dp_valid),        32'(m_g >= 0));
                check("dp_data_in",  32'(dp_data_in),      32'(m_exp));
                check("a_rsp_valid", 32'(sig_a_rsp_valid), 32'(m_fifo_a.size() > 0));
                check("a_rsp_data",  32'(sig_a_rsp_data),  32'((m_fifo_a.size() > 0) ? m_fifo_a[0] : '0));
                check("b_rsp_valid", 32'(sig_b_rsp_valid), 32'(m_fifo_b.size() > 0));
                check("b_rsp_data",  32'(sig_b_rsp_data),  32'((m_fifo_b.size() > 0) ? m_fifo_b[0] : '0));

                if (!rst_n) begin
                    m_fifo_a.delete();
                    m_fifo_b.delete();
                    m_flight.delete();
                    m_credit[0] = 0;
                    m_credit[1] = 0;
                    m_rr        = 0;
                end else begin
                    if (m_fifo_a.size() > 0 && sig_a_rsp_ready) begin
                        void'(m_fifo_a.pop_front());
                        m_credit[0]--;
                    end
                    if (m_fifo_b.size() > 0 && sig_b_rsp_ready) begin
                        void'(m_fifo_b.pop_front());
                        m_credit[1]--;
                    end
                    while (m_flight.size() > 0 && m_flight[0].due == m_cyc) begin
                        m_f = m_flight.pop_front();
                        if (m_f.chan == 0) m_fifo_a.push_back(m_f.data);
                        else               m_fifo_b.push_back(m_f.data);
                    end
                    if (m_g >= 0) begin
                        m_f.chan = m_g;
                        m_f.data = m_exp + DW'(1);
                        m_f.due  = m_cyc + LAT;
                        m_flight.push_back(m_f);
                        m_credit[m_g]++;
                        m_rr = 1 - m_g;
                    end
                end
            end
            m_cyc++;
            acc_a  = sig_a_req_valid && sig_a_req_ready;
            acc_b  = sig_b_req_valid && sig_b_req_ready;
            dp_cap = dp_data_in;
        end
    end

    // ---------------- directed stimulus ----------------
    int            nb;
    int            na;
    logic [DW-1:0] popped [$];
    logic [DW-1:0] want_b [5] = '{8'h81, 8'h82, 8'h83, 8'h84, 8'h85};

    initial begin
        rst_n = 1'b0;
        sig_a_req_valid = 1'b0; sig_a_req_data = '0; sig_a_rsp_ready = 1'b1;
        sig_b_req_valid = 1'b0; sig_b_req_data = '0; sig_b_rsp_ready = 1'b1;
        for (int i = 0; i < LAT; i++) dp_pipe[i] = '0;

        // Reset: requests during reset must not be accepted.
        tick();
        model_on = 1'b1;
        sig_a_req_valid = 1'b1;
        sig_b_req_valid = 1'b1;
        @(negedge clk);
        check("rst_a_req_ready", 32'(sig_a_req_ready), 32'd0);
        check("rst_dp_valid",    32'(dp_valid),        32'd0);
        check("rst_dp_data_in",  32'(dp_data_in),      32'd0);
        check("rst_a_rsp_valid", 32'(sig_a_rsp_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        sig_a_req_valid = 1'b0;
        sig_b_req_valid = 1'b0;

        // Single request: 0x3C from A in cycle 0 -> 0x3D visible in cycle 3.
        sig_a_req_valid = 1'b1;
        sig_a_req_data  = 8'h3C;
        @(negedge clk);
        check("single_a_ready", 32'(sig_a_req_ready), 32'd1);
        check("single_dp_data", 32'(dp_data_in),      32'h3C);
        tick();
        sig_a_req_valid = 1'b0;
        @(negedge clk);
        check("single_c1_rsp_valid", 32'(sig_a_rsp_valid), 32'd0);
        tick();
        @(negedge clk);
        check("single_c2_rsp_valid", 32'(sig_a_rsp_valid), 32'd0);
        tick();
        @(negedge clk);
        check("single_c3_rsp_valid", 32'(sig_a_rsp_valid), 32'd1);
        check("single_c3_rsp_data",  32'(sig_a_rsp_data),  32'h3D);
        tick();
        @(negedge clk);
        check("single_c4_rsp_valid", 32'(sig_a_rsp_valid), 32'd0);
        tick();

        // Contention from reset: A, B, A, B ...
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        sig_a_req_valid = 1'b1; sig_a_req_data = 8'h10;
        sig_b_req_valid = 1'b1; sig_b_req_data = 8'h40;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("alt_a_ready", 32'(sig_a_req_ready), 32'((i % 2) == 0));
            check("alt_b_ready", 32'(sig_b_req_ready), 32'((i % 2) == 1));
            tick();
        end

        // Backpressure on B: exactly DEPTH B grants, then A every cycle.
        rst_n = 1'b0;
        sig_a_req_valid = 1'b0;
        sig_b_req_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        sig_a_req_valid = 1'b1; sig_a_req_data = 8'h20;
        sig_b_req_valid = 1'b1; sig_b_req_data = 8'h80;
        sig_b_rsp_ready = 1'b0;
        nb = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (sig_b_req_ready) nb++;
            if (i >= 8) begin
                check("bp_a_ready", 32'(sig_a_req_ready), 32'd1);
                check("bp_b_ready", 32'(sig_b_req_ready), 32'd0);
            end
            tick();
        end
        check("bp_b_grant_count", 32'(nb), 32'(DEPTH));

        // Credit release: one pop of B -> exactly one more B grant.
        popped.delete();
        sig_b_rsp_ready = 1'b1;
        nb = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (sig_b_rsp_valid && sig_b_rsp_ready) popped.push_back(sig_b_rsp_data);
            if (sig_b_req_ready) nb++;
            if (i == 0) check("rel_first_pop", 32'(sig_b_rsp_data), 32'h81);
            if (i == 1) check("rel_b_regrant", 32'(sig_b_req_ready), 32'd1);
            tick();
            sig_b_rsp_ready = 1'b0;
        end
        check("rel_b_grant_count", 32'(nb), 32'd1);

        // Drain B and confirm issue order.
        sig_a_req_valid = 1'b0;
        sig_b_req_valid = 1'b0;
        sig_b_rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (sig_b_rsp_valid && sig_b_rsp_ready) popped.push_back(sig_b_rsp_data);
            tick();
        end
        check("order_b_count", 32'(popped.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            check("order_b_data", 32'((i < popped.size()) ? popped[i] : '0), 32'(want_b[i]));

        // Reset with two results in flight.
        sig_a_req_valid = 1'b1; sig_a_req_data = 8'h55;
        @(negedge clk);
        check("mid_a_ready", 32'(sig_a_req_ready), 32'd1);
        tick();
        sig_a_req_valid = 1'b0;
        sig_b_req_valid = 1'b1; sig_b_req_data = 8'h66;
        @(negedge clk);
        check("mid_b_ready", 32'(sig_b_req_ready), 32'd1);
        tick();
        sig_b_req_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("mid_a_rsp_valid", 32'(sig_a_rsp_valid), 32'd0);
            check("mid_b_rsp_valid", 32'(sig_b_rsp_valid), 32'd0);
            tick();
        end
        // Credits restart at zero: a stalled A takes exactly DEPTH grants.
        sig_a_rsp_ready = 1'b0;
        sig_a_req_valid = 1'b1;
        na = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (sig_a_req_ready) na++;
            tick();
        end
        check("mid_a_credit_grants", 32'(na), 32'(DEPTH));
        sig_a_req_valid = 1'b0;
        sig_a_rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dual_chan_arb.md
DUAL_CHAN_ARB -- requirements
Module: dual_chan_arb

Interface
REQ-001 Parameter DW, default 8: data width of requests, responses and shared datapath.
REQ-002 Parameter LAT, default 2: fixed latency in cycles of the shared datapath; legal range is LAT >= 1.
REQ-003 Parameter DEPTH, default 4: per-channel response FIFO depth; legal range is DEPTH >= 2.
REQ-004 clk  input  1  single rising-edge clock for all state.
REQ-005 rst_n  input  1  reset: synchronous, active-low.
REQ-006 sig_{a,b}_req_valid  input  1  channel request valid.
REQ-007 sig_{a,b}_req_ready  output  1  channel request accepted this cycle.
REQ-008 sig_{a,b}_req_data  input  DW  channel request operand.
REQ-009 sig_{a,b}_rsp_valid  output  1  channel response available.
REQ-010 sig_{a,b}_rsp_ready  input  1  channel response consumed.
REQ-011 sig_{a,b}_rsp_data  output  DW  channel response data.
REQ-012 dp_valid  output  1  operand issued to the shared datapath this cycle.
REQ-013 dp_data_in  output  DW  operand to the shared datapath.
REQ-014 dp_data_out  input  DW  datapath result, valid exactly LAT cycles after the matching dp_valid.

Function
REQ-015 The block SHALL accept at most one request per cycle; a request transfers when req_valid && req_ready.
REQ-016 Channel X SHALL be eligible when req_valid_X = 1 and credit_X < DEPTH, where credit_X = in-flight results for X plus FIFO_X occupancy.
REQ-017 Round-robin rule: pointer rr names the preferred channel; both eligible -> grant rr; one eligible -> grant it; after any grant, rr <= the other channel; no grant -> rr holds.
REQ-018 req_ready_X SHALL be 1 only in a cycle where X is granted; req_ready may depend combinationally on req_valid.
REQ-019 On grant, dp_valid = 1 and dp_data_in = granted req_data in the same cycle; otherwise dp_valid = 0 and dp_data_in = 0.
REQ-020 A LAT-stage tag pipeline of {valid, channel} SHALL track each issue; when the tag reaches stage LAT, dp_data_out SHALL be pushed into that channel's FIFO.
REQ-021 dp_data_out SHALL be ignored in any cycle with no valid tag at stage LAT.
REQ-022 rsp_valid_X = FIFO_X non-empty; rsp_data_X = FIFO_X head, 0 when empty; pop when rsp_valid_X && rsp_ready_X.
REQ-023 Latency: a request accepted in cycle T SHALL produce rsp_valid in cycle T+LAT+1 if FIFO_X was empty.
REQ-024 credit_X SHALL increment on a grant to X and decrement on a pop from X; a grant and a pop in the same cycle leave it unchanged.
REQ-025 Credit gating SHALL guarantee that the FIFOs never overflow; a push into a full FIFO is an assertion failure.
REQ-026 FIFO push and pop in the same cycle SHALL both take effect.
REQ-027 Per-channel response order SHALL equal request acceptance order; no ordering is defined across channels.

Reset
REQ-028 While rst_n = 0 at a clk edge: FIFOs are emptied, credits = 0, all tags invalid, rr = channel A.
REQ-029 Output values during and after reset: req_ready = 0, rsp_valid = 0, rsp_data = 0, dp_valid = 0, dp_data_in = 0.
REQ-030 Reset mid-operation SHALL discard in-flight results; datapath outputs arriving after reset SHALL NOT be pushed.

Structure
REQ-031 Package dual_chan_arb_pkg SHALL hold the chan_e enum (CH_A, CH_B) and the tag_t struct {logic valid; chan_e chan}.
REQ-032 Sub-module resp_fifo, a synchronous FIFO parameterised by DW and DEPTH, SHALL be instantiated once per channel.

Verification
REQ-033 Single request: A issues 0x3C with datapath model = +1 and LAT = 2, accepted in cycle 0 -> sig_a_rsp_valid in cycle 3 with data 0x3D.
REQ-034 Contention: A and B valid continuously from reset -> grants alternate A, B, A, B…, with A first.
REQ-035 Backpressure: sig_b_rsp_ready = 0 and B streams requests -> exactly DEPTH (4) B grants, then sig_b_req_ready = 0 while A continues to be granted every cycle.
REQ-036 Credit release: after REQ-035, one cycle of sig_b_rsp_ready = 1 -> one further B grant, no FIFO overflow, B data in issue order.
REQ-037 Reset mid-flight: rst_n low for 1 cycle with 2 results in flight -> no rsp_valid for either channel afterwards and credits at 0.
